// File: rtl/vc_fifo_pkg.sv
// Shared defaults and width helper for the virtual-channel FIFO bank.
package vc_fifo_pkg;

  localparam int DEF_DATA_SIZE = 6;
  localparam int DEF_ADDR_W    = 2;
  localparam int DEF_NUM_VC    = 2;

  // Bits needed to name one of n channels; never narrower than one bit.
  function automatic int vcWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vc_fifo_chan.sv
// One virtual channel: storage, pointers, occupancy count, status flags,
// hysteretic pause and sticky error.
module vc_fifo_chan
  import vc_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset_L,
  input  logic                 i_push,
  input  logic [DATA_SIZE-1:0] i_data,
  input  logic                 i_pop,
  input  logic [ADDR_W:0]      i_afThr,
  input  logic [ADDR_W:0]      i_aeThr,
  input  logic                 i_errClr,
  output logic [DATA_SIZE-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_almostFull,
  output logic                 o_almostEmpty,
  output logic                 o_pause,
  output logic                 o_error
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_wrPtr;
  logic [ADDR_W-1:0]    r_rdPtr;
  logic [ADDR_W:0]      r_count;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_pause;
  logic                 r_error;

  logic                 w_empty;
  logic                 w_full;
  logic                 w_pushOk;
  logic                 w_popOk;
  logic                 w_errEvent;
  logic [ADDR_W:0]      w_countNext;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // A full channel still takes a push when a pop frees a slot on the same
  // edge; an empty channel never forwards a same-cycle push to the reader.
  assign w_popOk    = i_pop && !w_empty;
  assign w_pushOk   = i_push && (!w_full || w_popOk);
  assign w_errEvent = (i_push && w_full && !i_pop) || (i_pop && w_empty);

  // Next occupancy, used by the count register and the pause hysteresis.
  always_comb begin
    w_countNext = r_count;
    if (w_pushOk && !w_popOk) begin
      w_countNext = r_count + 1'b1;
    end else if (!w_pushOk && w_popOk) begin
      w_countNext = r_count - 1'b1;
    end
  end

  // Storage write; contents are don't-care after reset, so no reset here.
  always_ff @(posedge i_clk) begin
    if (w_pushOk) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  // Pointers, count, read register, pause and sticky error.
  always_ff @(posedge i_clk or negedge i_reset_L) begin
    if (!i_reset_L) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_pause <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_popOk) begin
        r_rdPtr <= r_rdPtr + 1'b1;
        r_data  <= r_mem[r_rdPtr];
      end
      r_valid <= w_popOk;
      r_count <= w_countNext;
      if (w_countNext >= i_afThr) begin
        r_pause <= 1'b1;
      end else if (w_countNext <= i_aeThr) begin
        r_pause <= 1'b0;
      end
      r_error <= w_errEvent | (r_error & ~i_errClr);
    end
  end

  assign o_data        = r_data;
  assign o_valid       = r_valid;
  assign o_pause       = r_pause;
  assign o_error       = r_error;
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_almostFull  = (r_count >= i_afThr);
  assign o_almostEmpty = !w_empty && (r_count <= i_aeThr);

endmodule

// File: rtl/vc_fifo_bank.sv
// Bank of independent FIFO channels sharing one write port and per-channel
// read ports; the top only steers the push to the addressed channel.
module vc_fifo_bank
  import vc_fifo_pkg::*;
#(
  parameter int  DATA_SIZE = DEF_DATA_SIZE,
  parameter int  ADDR_W    = DEF_ADDR_W,
  parameter int  NUM_VC    = DEF_NUM_VC,
  localparam int VC_W      = vcWidth(NUM_VC)
) (
  input  logic                        clk,
  input  logic                        reset_L,
  input  logic                        push,
  input  logic [VC_W-1:0]             push_vc,
  input  logic [DATA_SIZE-1:0]        data_in,
  input  logic [NUM_VC-1:0]           pop,
  input  logic [ADDR_W:0]             af_thr,
  input  logic [ADDR_W:0]             ae_thr,
  input  logic [NUM_VC-1:0]           err_clr,
  output logic [NUM_VC*DATA_SIZE-1:0] data_out,
  output logic [NUM_VC-1:0]           valid_out,
  output logic [NUM_VC-1:0]           fifo_empty,
  output logic [NUM_VC-1:0]           fifo_full,
  output logic [NUM_VC-1:0]           almost_full,
  output logic [NUM_VC-1:0]           almost_empty,
  output logic [NUM_VC-1:0]           fifo_pause,
  output logic [NUM_VC-1:0]           fifo_error
);

  logic [NUM_VC-1:0] w_pushSel;

  // One-hot push steering; an out-of-range push_vc addresses no channel.
  always_comb begin
    w_pushSel = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      w_pushSel[i] = push && (push_vc == VC_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : gen_chan
    vc_fifo_chan #(
      .DATA_SIZE (DATA_SIZE),
      .ADDR_W    (ADDR_W)
    ) u_chan (
      .i_clk         (clk),
      .i_reset_L     (reset_L),
      .i_push        (w_pushSel[g]),
      .i_data        (data_in),
      .i_pop         (pop[g]),
      .i_afThr       (af_thr),
      .i_aeThr       (ae_thr),
      .i_errClr      (err_clr[g]),
      .o_data        (data_out[g*DATA_SIZE +: DATA_SIZE]),
      .o_valid       (valid_out[g]),
      .o_empty       (fifo_empty[g]),
      .o_full        (fifo_full[g]),
      .o_almostFull  (almost_full[g]),
      .o_almostEmpty (almost_empty[g]),
      .o_pause       (fifo_pause[g]),
      .o_error       (fifo_error[g])
    );
  end

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed bench for vc_fifo_bank with default parameters (6-bit words,
// depth 4, two channels).
module tb_vc_fifo_bank;

  logic        clk;
  logic        reset_L;
  logic        push;
  logic [0:0]  push_vc;
  logic [5:0]  data_in;
  logic [1:0]  pop;
  logic [2:0]  af_thr;
  logic [2:0]  ae_thr;
  logic [1:0]  err_clr;
  logic [11:0] data_out;
  logic [1:0]  valid_out;
  logic [1:0]  fifo_empty;
  logic [1:0]  fifo_full;
  logic [1:0]  almost_full;
  logic [1:0]  almost_empty;
  logic [1:0]  fifo_pause;
  logic [1:0]  fifo_error;

  int nChecks = 0;
  int nFails  = 0;

  logic [5:0] d0;
  logic [5:0] d1;
  assign d0 = data_out[5:0];
  assign d1 = data_out[11:6];

  vc_fifo_bank dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .push         (push),
    .push_vc      (push_vc),
    .data_in      (data_in),
    .pop          (pop),
    .af_thr       (af_thr),
    .ae_thr       (ae_thr),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_pause   (fifo_pause),
    .fifo_error   (fifo_error)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push    = 1'b0;
    pop     = 2'b00;
    err_clr = 2'b00;
  endtask

  task automatic pushWord(input logic [0:0] vc, input logic [5:0] val);
    push    = 1'b1;
    push_vc = vc;
    data_in = val;
    tick();
    push    = 1'b0;
  endtask

  task automatic test_reset();
    nChecks++;
    if (fifo_empty !== 2'b11) begin nFails++; $display("[TB] FAIL reset_empty: got %b want 11", fifo_empty); end
    nChecks++;
    if ({fifo_full, almost_full, almost_empty, fifo_pause, fifo_error} !== 10'b0) begin
      nFails++; $display("[TB] FAIL reset_flags: got %b want 0", {fifo_full, almost_full, almost_empty, fifo_pause, fifo_error});
    end
    nChecks++;
    if ({data_out, valid_out} !== 14'b0) begin nFails++; $display("[TB] FAIL reset_data: got %h want 0", {data_out, valid_out}); end
    #3 reset_L = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int k = 1; k <= 4; k++) pushWord(1'b0, 6'(k));
    nChecks++;
    if (fifo_full !== 2'b01) begin nFails++; $display("[TB] FAIL fill_full: got %b want 01", fifo_full); end
    nChecks++;
    if (fifo_empty !== 2'b10) begin nFails++; $display("[TB] FAIL fill_vc1_untouched: got %b want 10", fifo_empty); end
    for (int k = 1; k <= 4; k++) begin
      pop = 2'b01;
      tick();
      nChecks++;
      if (valid_out !== 2'b01 || d0 !== 6'(k)) begin
        nFails++; $display("[TB] FAIL drain_%0d: got valid %b data %h want 01 %h", k, valid_out, d0, 6'(k));
      end
    end
    pop = 2'b00;
    nChecks++;
    if (fifo_empty[0] !== 1'b1) begin nFails++; $display("[TB] FAIL drain_empty: got %b want 1", fifo_empty[0]); end
    tick();
    nChecks++;
    if (valid_out !== 2'b00 || d0 !== 6'h04) begin
      nFails++; $display("[TB] FAIL drain_hold: got valid %b data %h want 00 04", valid_out, d0);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 4; k++) pushWord(1'b0, 6'(8'h0A + k));
    pushWord(1'b0, 6'h3F);
    nChecks++;
    if (fifo_error !== 2'b01 || fifo_full[0] !== 1'b1) begin
      nFails++; $display("[TB] FAIL overflow_err: got err %b full %b want 01 1", fifo_error, fifo_full[0]);
    end
    err_clr = 2'b01;
    tick();
    err_clr = 2'b00;
    nChecks++;
    if (fifo_error !== 2'b00) begin nFails++; $display("[TB] FAIL overflow_clr: got %b want 00", fifo_error); end
    for (int k = 0; k < 4; k++) begin
      pop = 2'b01;
      tick();
      nChecks++;
      if (d0 !== 6'(8'h0A + k)) begin nFails++; $display("[TB] FAIL overflow_data_%0d: got %h want %h", k, d0, 6'(8'h0A + k)); end
    end
    pop = 2'b00;
  endtask

  task automatic test_pause();
    pushWord(1'b1, 6'h21);
    pushWord(1'b1, 6'h22);
    nChecks++;
    if (fifo_pause[1] !== 1'b0) begin nFails++; $display("[TB] FAIL pause_at2: got %b want 0", fifo_pause[1]); end
    pushWord(1'b1, 6'h23);
    nChecks++;
    if (fifo_pause[1] !== 1'b1 || almost_full[1] !== 1'b1) begin
      nFails++; $display("[TB] FAIL pause_set: got pause %b af %b want 1 1", fifo_pause[1], almost_full[1]);
    end
    pop = 2'b10;
    tick();
    nChecks++;
    if (fifo_pause[1] !== 1'b1 || d1 !== 6'h21) begin
      nFails++; $display("[TB] FAIL pause_hold: got pause %b data %h want 1 21", fifo_pause[1], d1);
    end
    tick();
    nChecks++;
    if (fifo_pause[1] !== 1'b0 || almost_empty[1] !== 1'b1 || d1 !== 6'h22) begin
      nFails++; $display("[TB] FAIL pause_release: got pause %b ae %b data %h want 0 1 22", fifo_pause[1], almost_empty[1], d1);
    end
    tick();
    pop = 2'b00;
    nChecks++;
    if (d1 !== 6'h23 || fifo_empty[1] !== 1'b1) begin
      nFails++; $display("[TB] FAIL pause_drain: got data %h empty %b want 23 1", d1, fifo_empty[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] expQ[$];
    logic [5:0] expV;
    for (int k = 0; k < 4; k++) begin
      pushWord(1'b0, 6'(8'h11 + k));
      expQ.push_back(6'(8'h11 + k));
    end
    for (int k = 0; k < 10; k++) begin
      push    = 1'b1;
      push_vc = 1'b0;
      data_in = 6'(8'h20 + k);
      pop     = 2'b01;
      tick();
      expV = expQ.pop_front();
      expQ.push_back(6'(8'h20 + k));
      nChecks++;
      if (valid_out[0] !== 1'b1 || d0 !== expV || fifo_full[0] !== 1'b1 || fifo_error[0] !== 1'b0) begin
        nFails++; $display("[TB] FAIL b2b_%0d: got v%b d%h full%b err%b want v1 d%h full1 err0", k, valid_out[0], d0, fifo_full[0], fifo_error[0], expV);
      end
    end
    push = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pop = 2'b01;
      tick();
      expV = expQ.pop_front();
      nChecks++;
      if (d0 !== expV) begin nFails++; $display("[TB] FAIL b2b_drain_%0d: got %h want %h", k, d0, expV); end
    end
    pop = 2'b00;
  endtask

  task automatic test_empty_pushpop();
    push    = 1'b1;
    push_vc = 1'b0;
    data_in = 6'h15;
    pop     = 2'b01;
    tick();
    push = 1'b0;
    pop  = 2'b00;
    nChecks++;
    if (fifo_error[0] !== 1'b1 || valid_out[0] !== 1'b0 || fifo_empty[0] !== 1'b0 || almost_empty[0] !== 1'b1) begin
      nFails++; $display("[TB] FAIL empty_pushpop: got err%b v%b e%b ae%b want 1 0 0 1", fifo_error[0], valid_out[0], fifo_empty[0], almost_empty[0]);
    end
    pop     = 2'b01;
    err_clr = 2'b01;
    tick();
    idle();
    nChecks++;
    if (valid_out[0] !== 1'b1 || d0 !== 6'h15 || fifo_error[0] !== 1'b0) begin
      nFails++; $display("[TB] FAIL empty_followup: got v%b d%h err%b want 1 15 0", valid_out[0], d0, fifo_error[0]);
    end
  endtask

  task automatic test_err_collision();
    pop = 2'b10;
    tick();
    nChecks++;
    if (fifo_error !== 2'b10) begin nFails++; $display("[TB] FAIL underflow_err: got %b want 10", fifo_error); end
    err_clr = 2'b10;
    tick();
    nChecks++;
    if (fifo_error !== 2'b10) begin nFails++; $display("[TB] FAIL clr_collision: got %b want 10", fifo_error); end
    pop = 2'b00;
    tick();
    err_clr = 2'b00;
    nChecks++;
    if (fifo_error !== 2'b00) begin nFails++; $display("[TB] FAIL clr_after: got %b want 00", fifo_error); end
  endtask

  task automatic test_parallel();
    pushWord(1'b0, 6'h05);
    push    = 1'b1;
    push_vc = 1'b1;
    data_in = 6'h2A;
    pop     = 2'b01;
    tick();
    idle();
    nChecks++;
    if (valid_out !== 2'b01 || d0 !== 6'h05 || fifo_empty !== 2'b01) begin
      nFails++; $display("[TB] FAIL parallel_a: got v%b d%h e%b want 01 05 01", valid_out, d0, fifo_empty);
    end
    pop = 2'b10;
    tick();
    pop = 2'b00;
    nChecks++;
    if (valid_out !== 2'b10 || d1 !== 6'h2A || d0 !== 6'h05 || fifo_empty !== 2'b11) begin
      nFails++; $display("[TB] FAIL parallel_b: got v%b d1 %h d0 %h e%b want 10 2a 05 11", valid_out, d1, d0, fifo_empty);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) pushWord(1'b0, 6'(8'h31 + k));
    pop = 2'b01;
    tick();
    pop = 2'b00;
    nChecks++;
    if (valid_out !== 2'b01 || d0 !== 6'h31 || fifo_pause[0] !== 1'b1) begin
      nFails++; $display("[TB] FAIL prereset: got v%b d%h p%b want 01 31 1", valid_out, d0, fifo_pause[0]);
    end
    #2 reset_L = 1'b0;
    #1;
    nChecks++;
    if (fifo_empty !== 2'b11 || valid_out !== 2'b00 || data_out !== 12'h0 || fifo_pause !== 2'b00 || fifo_full !== 2'b00) begin
      nFails++; $display("[TB] FAIL async_reset: got e%b v%b d%h p%b f%b want 11 00 000 00 00", fifo_empty, valid_out, data_out, fifo_pause, fifo_full);
    end
    #1 reset_L = 1'b1;
    nChecks++;
    if (fifo_empty !== 2'b11) begin nFails++; $display("[TB] FAIL release_empty: got %b want 11", fifo_empty); end
    pop = 2'b01;
    tick();
    pop = 2'b00;
    nChecks++;
    if (valid_out[0] !== 1'b0 || fifo_error[0] !== 1'b1) begin
      nFails++; $display("[TB] FAIL discarded: got v%b err%b want 0 1", valid_out[0], fifo_error[0]);
    end
  endtask

  initial begin
    reset_L = 1'b0;
    push    = 1'b0;
    push_vc = 1'b0;
    data_in = 6'h00;
    pop     = 2'b00;
    err_clr = 2'b00;
    af_thr  = 3'd3;
    ae_thr  = 3'd1;
    #12;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_pause();
    test_back_to_back();
    test_empty_pushpop();
    test_err_collision();
    test_parallel();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/vc_fifo_bank.md
VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

Interface
REQ-001 Parameter DATA_SIZE, default 6: word width in bits.
REQ-002 Parameter ADDR_W, default 2: per-channel depth is 2**ADDR_W words.
REQ-003 Parameter NUM_VC, default 2: number of virtual channels, minimum 2.
REQ-004 Port clk, input, 1: single clock; all state is updated on the rising edge.
REQ-005 Port reset_L, input, 1: reset, asynchronous and active-low.
REQ-006 Port push, input, 1: write request.
REQ-007 Port push_vc, input, VC_W: target channel for push, where VC_W = clog2(NUM_VC).
REQ-008 Port data_in, input, DATA_SIZE: write data.
REQ-009 Port pop, input, NUM_VC: per-channel read request.
REQ-010 Port af_thr, input, ADDR_W+1: almost-full and pause-set threshold, shared by all channels.
REQ-011 Port ae_thr, input, ADDR_W+1: almost-empty and pause-release threshold, shared by all channels.
REQ-012 Port err_clr, input, NUM_VC: per-channel clear of the sticky error.
REQ-013 Port data_out, output, NUM_VC*DATA_SIZE: registered read data; channel i occupies slice [i*DATA_SIZE +: DATA_SIZE].
REQ-014 Port valid_out, output, NUM_VC: per-channel read-data-valid pulse.
REQ-015 Ports fifo_empty, fifo_full, almost_full, almost_empty, fifo_pause, fifo_error, each output, NUM_VC: per-channel status.

Function
REQ-016 Each channel SHALL keep a count in the range 0..2**ADDR_W, ADDR_W+1 bits wide; it never wraps.
REQ-017 Each channel's read and write pointers SHALL be ADDR_W bits and wrap modulo the depth.
REQ-018 A push SHALL be accepted when push=1 and channel push_vc is not full; data_in is written at wr_ptr, wr_ptr increments and count increments.
REQ-019 A pop on channel i SHALL be accepted when pop[i]=1 and count_i != 0.
REQ-020 On an accepted pop, data_out slice i SHALL load mem[rd_ptr] on the same edge, valid_out[i]=1 for exactly the following cycle, rd_ptr increments and count decrements. Latency: 1 cycle.
REQ-021 When no pop is accepted, data_out slice i SHALL hold its value and valid_out[i]=0.
REQ-022 An accepted push and an accepted pop on the same channel in the same cycle SHALL both complete, with count unchanged.
REQ-023 A full channel with push and pop in the same cycle SHALL accept both; the full check uses the pre-edge count.
REQ-024 An empty channel with push and pop in the same cycle SHALL accept the push only; there is no bypass; the pop is an error.
REQ-025 Push and pop on different channels are independent and SHALL all proceed in the same cycle.
REQ-026 Combinational flags SHALL be decoded from count: fifo_empty = (count==0); fifo_full = (count==2**ADDR_W); almost_full = (count>=af_thr); almost_empty = (count!=0 && count<=ae_thr).
REQ-027 fifo_pause SHALL be a register with hysteresis: set when next count >= af_thr; cleared when next count <= ae_thr; held otherwise.
REQ-028 fifo_error SHALL be a sticky register, set on push to a full channel without a same-cycle pop, or on pop of an empty channel.
REQ-029 A rejected request SHALL change no pointer, count or data.
REQ-030 err_clr[i] SHALL clear fifo_error[i]; if a new error occurs in the same cycle, fifo_error stays 1.
REQ-031 Behaviour when af_thr <= ae_thr is not specified; the bench SHALL not drive it.

Reset
REQ-032 reset_L=0 SHALL asynchronously clear all pointers, counts, data_out, valid_out, fifo_pause and fifo_error to 0, and memory contents become don't-care.
REQ-033 While in reset, fifo_empty=1 and all other status flags are 0.
REQ-034 Reset asserted mid-operation SHALL discard all stored words; the first edge after release behaves as if from empty.

Structure
REQ-035 Package vc_fifo_pkg SHALL hold the default DATA_SIZE, ADDR_W and NUM_VC values and the clog2-based width function.
REQ-036 One sub-module, vc_fifo_chan, SHALL implement a single channel (memory array, pointers, count, flags, pause, error); it is instantiated NUM_VC times by generate, and the top level only decodes push_vc.

Verification
REQ-037 Reset, then push 4 words 0x01..0x04 to VC0 -> fifo_full[0]=1 and VC1 untouched; then 4 pops -> data_out slice 0 = 0x01..0x04, each one cycle after its pop, and fifo_empty[0]=1.
REQ-038 With VC0 full, push 0x3F without pop -> fifo_error[0]=1 and count stays 4; then err_clr[0] -> fifo_error[0]=0 next cycle.
REQ-039 With af_thr=3 and ae_thr=1: fill VC1 to 3 -> fifo_pause[1]=1; pop to 2 -> pause stays 1; pop to 1 -> pause=0.
REQ-040 With VC0 full, push and pop in the same cycle -> no error, count stays 4, and pointers wrap correctly over 10 such cycles with data in order.
REQ-041 With VC0 empty, push 0x15 and pop in the same cycle -> fifo_error[0]=1, valid_out[0]=0, count=1; the next pop returns 0x15.
REQ-042 Assert reset_L low between edges with 3 words held -> outputs clear immediately; after release fifo_empty=all ones.
